// File: rtl/db_sense_ctrl_if.sv
// -----------------------------------------------------------------------------
// db_sense_ctrl_if
//   Status/control bundle between the slow-control logic and one daughterboard
//   SENSE sequencer (db_sense_ctrl).
//
//   Signals
//     enable_i    : scanning enable (slow control -> sequencer)
//     scan_req_i  : single-cycle request for an immediate scan
//     busy_o      : scan in progress
//     scan_done_o : one-cycle pulse when a sample has been taken
//     present_o   : debounced daughterboard-present flag
//     changed_o   : one-cycle pulse when present_o toggles
//
//   Modports
//     master : slow-control side (drives enable/request, reads status)
//     slave  : sequencer side
// -----------------------------------------------------------------------------
`default_nettype none

interface db_sense_ctrl_if;
  logic enable_i;
  logic scan_req_i;
  logic busy_o;
  logic scan_done_o;
  logic present_o;
  logic changed_o;

  modport master (
    output enable_i,
    output scan_req_i,
    input  busy_o,
    input  scan_done_o,
    input  present_o,
    input  changed_o
  );

  modport slave (
    input  enable_i,
    input  scan_req_i,
    output busy_o,
    output scan_done_o,
    output present_o,
    output changed_o
  );
endinterface

`default_nettype wire

// File: rtl/db_sense_ctrl.sv
// -----------------------------------------------------------------------------
// db_sense_ctrl
//   Sequences the daughterboard SENSE pad of one slot. SENSE sits on a shared
//   net that is weakly pulled up when no board is fitted and pulled down by a
//   fitted board. Periodically (or on request) the pad is released, left to
//   settle, sampled through a 2-FF synchronizer and the sample is debounced
//   into a stable present flag with a change pulse.
//
//   Build option
//     DB_SENSE_PRECHARGE_EN : when defined, every scan first drives SENSE high
//                             for PRECHARGE_CYCLES cycles before releasing it,
//                             so a present board has to actively pull the net
//                             low (residual charge cannot fake a board).
//                             When undefined, sense_o/sense_oe_o are tied 0
//                             and a scan goes straight to the settle phase.
//
//   Parameters
//     SCAN_PERIOD      : cycles spent idle between automatic scans (>=2)
//     SETTLE_CYCLES    : cycles the pad floats before sampling (>=3)
//     DEBOUNCE         : consecutive disagreeing samples to flip present (>=1)
//     PRECHARGE_CYCLES : cycles SENSE is driven high (option only, >=1)
//
//   Ports
//     clk_i      : system clock
//     rst_n_i    : asynchronous active-low reset
//     ctl        : status/control bundle (db_sense_ctrl_if.slave)
//     sense_i    : pad input from the IOBUF (asynchronous)
//     sense_o    : pad output value
//     sense_oe_o : pad output enable, 1 = FPGA drives
// -----------------------------------------------------------------------------
`default_nettype none

module db_sense_ctrl #(
  parameter int unsigned SCAN_PERIOD      = 1000,
  parameter int unsigned SETTLE_CYCLES    = 16,
  parameter int unsigned DEBOUNCE         = 3,
  parameter int unsigned PRECHARGE_CYCLES = 4
) (
  input  wire logic      clk_i,
  input  wire logic      rst_n_i,
  db_sense_ctrl_if.slave ctl,
  input  wire logic      sense_i,
  output logic           sense_o,
  output logic           sense_oe_o
);

  // ---------------------------------------------------------------------------
  // Widths and constants
  // ---------------------------------------------------------------------------
  localparam int unsigned PER_W   = $clog2(SCAN_PERIOD);
  // One phase timer serves both precharge and settle, sized for the longer one.
  localparam int unsigned TMR_MAX = (SETTLE_CYCLES > PRECHARGE_CYCLES) ?
                                    SETTLE_CYCLES : PRECHARGE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX);
  localparam int unsigned DBC_W   = $clog2(DEBOUNCE + 1);

  localparam logic [PER_W-1:0] PER_RELOAD  = PER_W'(SCAN_PERIOD - 1);
  localparam logic [PER_W-1:0] PER_ZERO    = PER_W'(0);
  localparam logic [PER_W-1:0] PER_ONE     = PER_W'(1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO    = TMR_W'(0);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [DBC_W-1:0] DBC_ZERO    = DBC_W'(0);
  localparam logic [DBC_W-1:0] DBC_ONE     = DBC_W'(1);
  // Count value at which the next disagreeing sample flips present_o.
  localparam logic [DBC_W-1:0] DBC_LAST    = DBC_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef DB_SENSE_PRECHARGE_EN
    ST_PRECHG = 2'd1,
`endif
    ST_SETTLE = 2'd2,
    ST_SAMPLE = 2'd3
  } state_e;

  // First busy state of a scan and the timer value that goes with it.
`ifdef DB_SENSE_PRECHARGE_EN
  localparam logic [TMR_W-1:0] PRE_LOAD   = TMR_W'(PRECHARGE_CYCLES - 1);
  localparam state_e           ST_FIRST   = ST_PRECHG;
  localparam logic [TMR_W-1:0] FIRST_LOAD = PRE_LOAD;
`else
  localparam state_e           ST_FIRST   = ST_SETTLE;
  localparam logic [TMR_W-1:0] FIRST_LOAD = SETTLE_LOAD;
`endif

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e           state_r;
  state_e           state_nxt_s;
  logic [TMR_W-1:0] tmr_r;
  logic [TMR_W-1:0] tmr_nxt_s;

  logic             sense_meta_r;
  logic             sense_sync_r;
  logic             sense_s;

  logic [PER_W-1:0] per_cnt_r;
  logic [PER_W-1:0] per_cnt_nxt_s;
  logic             pend_r;
  logic             pend_nxt_s;
  logic [DBC_W-1:0] dbc_r;
  logic [DBC_W-1:0] dbc_nxt_s;
  logic             present_r;
  logic             present_nxt_s;
  logic             changed_r;
  logic             changed_nxt_s;

  logic             busy_r;
  logic             busy_nxt_s;
  logic             done_r;
  logic             done_nxt_s;

  logic             start_s;
  logic             sample_s;
  logic             sample_p_s;

  // ---------------------------------------------------------------------------
  // Decoded events
  // ---------------------------------------------------------------------------
  // Period expiry and a request in the same cycle collapse into this one start.
  assign start_s    = (state_r == ST_IDLE) && ctl.enable_i &&
                      ((per_cnt_r == PER_ZERO) || ctl.scan_req_i || pend_r);
  // A sample only counts when the scan was not aborted in its last cycle.
  assign sample_s   = (state_r == ST_SAMPLE) && ctl.enable_i;
  // A low pad means a board is pulling the net down.
  assign sample_p_s = ~sense_s;
  assign sense_s    = sense_sync_r;

  // ---------------------------------------------------------------------------
  // Pad synchronizer
  // ---------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous pad; resets to "absent" (high).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sense_meta_r <= 1'b1;
      sense_sync_r <= 1'b1;
    end else begin
      sense_meta_r <= sense_i;
      sense_sync_r <= sense_meta_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan sequencer FSM
  // ---------------------------------------------------------------------------
  // State register and phase timer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      tmr_r   <= TMR_ZERO;
    end else begin
      state_r <= state_nxt_s;
      tmr_r   <= tmr_nxt_s;
    end
  end

  // Next-state logic; dropping enable_i in any busy state aborts to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    tmr_nxt_s   = tmr_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = ST_FIRST;
          tmr_nxt_s   = FIRST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
          tmr_nxt_s   = TMR_ZERO;
        end
      end
`ifdef DB_SENSE_PRECHARGE_EN
      ST_PRECHG: begin
        if (!ctl.enable_i) begin
          state_nxt_s = ST_IDLE;
          tmr_nxt_s   = TMR_ZERO;
        end else if (tmr_r == TMR_ZERO) begin
          state_nxt_s = ST_SETTLE;
          tmr_nxt_s   = SETTLE_LOAD;
        end else begin
          state_nxt_s = ST_PRECHG;
          tmr_nxt_s   = tmr_r - TMR_ONE;
        end
      end
`endif
      ST_SETTLE: begin
        if (!ctl.enable_i) begin
          state_nxt_s = ST_IDLE;
          tmr_nxt_s   = TMR_ZERO;
        end else if (tmr_r == TMR_ZERO) begin
          state_nxt_s = ST_SAMPLE;
          tmr_nxt_s   = TMR_ZERO;
        end else begin
          state_nxt_s = ST_SETTLE;
          tmr_nxt_s   = tmr_r - TMR_ONE;
        end
      end
      ST_SAMPLE: begin
        state_nxt_s = ST_IDLE;
        tmr_nxt_s   = TMR_ZERO;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        tmr_nxt_s   = TMR_ZERO;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = sample_s;
  end

  // Registered status outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

`ifdef DB_SENSE_PRECHARGE_EN
  logic sense_oe_r;
  logic sense_oe_nxt_s;

  // The pad is driven only while precharging, never while the pull settles.
  always_comb begin
    sense_oe_nxt_s = (state_nxt_s == ST_PRECHG);
  end

  // Registered pad drive; the async reset releases the pad immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sense_oe_r <= 1'b0;
    end else begin
      sense_oe_r <= sense_oe_nxt_s;
    end
  end

  // Precharge always drives a high level, so the value follows the enable.
  assign sense_oe_o = sense_oe_r;
  assign sense_o    = sense_oe_r;
`else
  assign sense_oe_o = 1'b0;
  assign sense_o    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Period counter, pending request and debounce
  // ---------------------------------------------------------------------------
  // Next values of the scan bookkeeping and the debounce filter.
  always_comb begin
    per_cnt_nxt_s = per_cnt_r;
    pend_nxt_s    = pend_r;
    dbc_nxt_s     = dbc_r;
    present_nxt_s = present_r;
    changed_nxt_s = 1'b0;

    // Disabled (idle or aborting) holds the counter at reload, so re-enabling
    // always restarts a full period.
    if (!ctl.enable_i) begin
      per_cnt_nxt_s = PER_RELOAD;
    end else if (state_r == ST_IDLE) begin
      if (start_s) begin
        per_cnt_nxt_s = per_cnt_r;
      end else begin
        per_cnt_nxt_s = per_cnt_r - PER_ONE;
      end
    end else if (sample_s) begin
      per_cnt_nxt_s = PER_RELOAD;
    end else begin
      per_cnt_nxt_s = per_cnt_r;
    end

    // The pending flag is consumed when the scan it asks for starts; a
    // request arriving during a scan survives its completion so the follow-up
    // scan leaves IDLE after a single cycle.
    if (!ctl.enable_i) begin
      pend_nxt_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      pend_nxt_s = 1'b0;
    end else if (ctl.scan_req_i) begin
      pend_nxt_s = 1'b1;
    end else begin
      pend_nxt_s = pend_r;
    end

    // Debounce: agreement clears the count; the DEBOUNCE-th consecutive
    // disagreement flips present and clears, so the count never wraps.
    if (sample_s) begin
      if (sample_p_s == present_r) begin
        dbc_nxt_s = DBC_ZERO;
      end else if (dbc_r >= DBC_LAST) begin
        dbc_nxt_s     = DBC_ZERO;
        present_nxt_s = sample_p_s;
        changed_nxt_s = 1'b1;
      end else begin
        dbc_nxt_s = dbc_r + DBC_ONE;
      end
    end else begin
      dbc_nxt_s = dbc_r;
    end
  end

  // Scan bookkeeping and debounce state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      per_cnt_r <= PER_RELOAD;
      pend_r    <= 1'b0;
      dbc_r     <= DBC_ZERO;
      present_r <= 1'b0;
      changed_r <= 1'b0;
    end else begin
      per_cnt_r <= per_cnt_nxt_s;
      pend_r    <= pend_nxt_s;
      dbc_r     <= dbc_nxt_s;
      present_r <= present_nxt_s;
      changed_r <= changed_nxt_s;
    end
  end

  assign ctl.busy_o      = busy_r;
  assign ctl.scan_done_o = done_r;
  assign ctl.present_o   = present_r;
  assign ctl.changed_o   = changed_r;

endmodule

`default_nettype wire

// File: tb/tb_db_sense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_db_sense_ctrl
//   Self-checking bench for db_sense_ctrl. A pad model resolves the SENSE net
//   (FPGA drive wins, otherwise a fitted board pulls low and the weak pull
//   holds it high). Expected timing comes from the scan phase lengths, and the
//   expected present/changed values come from a debounce model applied to the
//   board state seen by each completed scan.
// -----------------------------------------------------------------------------
module tb_db_sense_ctrl;

  localparam int SP = 20;
  localparam int SC = 4;
  localparam int DB = 3;
  localparam int PC = 2;
`ifdef DB_SENSE_PRECHARGE_EN
  localparam int PRE = PC;
`else
  localparam int PRE = 0;
`endif
  // Edges from the one that starts a scan to the one that raises scan_done_o.
  localparam int SCAN_LEN = PRE + SC + 1;
  localparam int BUDGET   = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic board = 1'b0;
  logic sense_i;
  logic sense_o;
  logic sense_oe;

  db_sense_ctrl_if bus ();

  assign sense_i = sense_oe ? sense_o : ~board;

  db_sense_ctrl #(
    .SCAN_PERIOD      (SP),
    .SETTLE_CYCLES    (SC),
    .DEBOUNCE         (DB),
    .PRECHARGE_CYCLES (PC)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .ctl        (bus),
    .sense_i    (sense_i),
    .sense_o    (sense_o),
    .sense_oe_o (sense_oe)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Debounce reference: present flag and run length of disagreeing samples.
  bit pres_m = 1'b0;
  int dbc_m  = 0;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Applies one completed sample to the reference; returns the expected pulse.
  function automatic bit model_scan(input bit p);
    if (p == pres_m) begin
      dbc_m = 0;
      return 1'b0;
    end
    dbc_m = dbc_m + 1;
    if (dbc_m >= DB) begin
      pres_m = p;
      dbc_m  = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.scan_req_i = 1'b0;
  endtask

  // Runs until the next scan_done_o (bounded), pulsing scan_req_i before the
  // ticks selected by req_mask, then checks timing, pad drive and debounce.
  task automatic wait_scan(input string tag, input int exp_cyc, input logic [31:0] req_mask);
    int oe_n    = 0;
    bit seen    = 1'b0;
    bit stray   = 1'b0;
    bit bad_lvl = 1'b0;
    bit exp_chg;
    for (int k = 0; k < BUDGET && !seen; k++) begin
      if (k < 32 && req_mask[k]) bus.scan_req_i = 1'b1;
      tick();
      if (sense_oe === 1'b1) begin
        oe_n++;
        if (sense_o !== 1'b1) bad_lvl = 1'b1;
      end
      if (bus.scan_done_o === 1'b1) seen = 1'b1;
      else if (bus.changed_o !== 1'b0) stray = 1'b1;
    end
    check_bit($sformatf("%s_seen", tag), seen, 1'b1);
    if (seen) begin
      check_int($sformatf("%s_done_cyc", tag), cyc, exp_cyc);
      check_int($sformatf("%s_oe_cycles", tag), oe_n, PRE);
      check_bit($sformatf("%s_busy_at_done", tag), bus.busy_o, 1'b0);
      exp_chg = model_scan(board);
      check_bit($sformatf("%s_present", tag), bus.present_o, pres_m);
      check_bit($sformatf("%s_changed", tag), bus.changed_o, exp_chg);
    end
    check_bit($sformatf("%s_stray_changed", tag), stray, 1'b0);
    check_bit($sformatf("%s_precharge_level", tag), bad_lvl, 1'b0);
  endtask

  task automatic scan_now(input string tag);
    wait_scan(tag, cyc + 1 + SCAN_LEN, 32'd1);
  endtask

  // Only valid right after a scan_done_o, reset release or re-enable.
  task automatic scan_period(input string tag);
    wait_scan(tag, cyc + SP + SCAN_LEN, 32'd0);
  endtask

  initial begin
    int r;
    int c0;
    bit any_done;
    bit any_busy;

    bus.enable_i   = 1'b1;
    bus.scan_req_i = 1'b0;
    board          = 1'b0;

    // Reset with the pad pulled high.
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_bit("rst_busy", bus.busy_o, 1'b0);
    check_bit("rst_done", bus.scan_done_o, 1'b0);
    check_bit("rst_present", bus.present_o, 1'b0);
    check_bit("rst_changed", bus.changed_o, 1'b0);
    check_bit("rst_oe", sense_oe, 1'b0);
    check_bit("rst_sense_o", sense_o, 1'b0);
    cyc   = 0;
    rst_n = 1'b1;

    // Absent board: first scan after one full period, nothing changes.
    scan_period("first");
    scan_period("second");

    // Board fitted: present rises on the third sample.
    board = 1'b1;
    scan_now("fit1");
    scan_now("fit2");
    scan_now("fit3");
    check_bit("fit_present", bus.present_o, 1'b1);

    // Single high glitches must not accumulate.
    board = 1'b0;
    scan_now("glitch_a");
    board = 1'b1;
    scan_now("glitch_a_ok");
    board = 1'b0;
    scan_now("glitch_b1");
    scan_now("glitch_b2");
    board = 1'b1;
    scan_now("glitch_b_ok");
    board = 1'b0;
    scan_now("glitch_c");
    check_bit("glitch_present", bus.present_o, 1'b1);
    board = 1'b1;
    scan_now("glitch_c_ok");

    // Two requests during SETTLE collapse into one follow-up scan.
    c0 = cyc;
    wait_scan("pend1", c0 + 1 + SCAN_LEN, 32'd1 | (32'd1 << (PRE + 1)) | (32'd1 << (PRE + 3)));
    wait_scan("pend2", cyc + 1 + SCAN_LEN, 32'd0);
    scan_period("pend_none");

    // Request on the very cycle the period expires starts a single scan.
    wait_scan("coinc", cyc + SP + SCAN_LEN, 32'd1 << (SP - 1));
    scan_period("coinc_single");

    // Randomized board state and request timing.
    for (int i = 0; i < 12; i++) begin
      board = 1'($urandom_range(0, 1));
      r     = int'($urandom_range(0, 24));
      if (r >= SP) scan_period("rnd_period");
      else wait_scan("rnd_req", cyc + r + 1 + SCAN_LEN, 32'd1 << r);
    end

    // Leave a partial debounce count, then abort a scan by dropping enable.
    board = ~pres_m;
    scan_now("pre_abort");
    bus.scan_req_i = 1'b1;
    tick();
    check_bit("abort_busy", bus.busy_o, 1'b1);
    check_bit("abort_oe_on", sense_oe, (PRE > 0));
    bus.enable_i = 1'b0;
    tick();
    check_bit("abort_oe_off", sense_oe, 1'b0);
    check_bit("abort_idle", bus.busy_o, 1'b0);
    any_done = bus.scan_done_o | bus.changed_o;
    any_busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) bus.scan_req_i = 1'b1;
      tick();
      any_done = any_done | bus.scan_done_o | bus.changed_o;
      any_busy = any_busy | bus.busy_o;
    end
    check_bit("abort_no_done", any_done, 1'b0);
    check_bit("disabled_req_ignored", any_busy, 1'b0);
    check_bit("abort_present", bus.present_o, pres_m);
    bus.enable_i = 1'b1;
    scan_period("reenable");
    scan_now("after_abort");

    // Asynchronous reset in the first busy cycle of a scan.
    board = 1'b1;
    scan_now("rst_fit1");
    scan_now("rst_fit2");
    scan_now("rst_fit3");
    check_bit("rst_pre_present", bus.present_o, 1'b1);
    bus.scan_req_i = 1'b1;
    tick();
    check_bit("arst_oe_before", sense_oe, (PRE > 0));
    #1 rst_n = 1'b0;
    #1;
    check_bit("arst_oe", sense_oe, 1'b0);
    check_bit("arst_sense_o", sense_o, 1'b0);
    check_bit("arst_busy", bus.busy_o, 1'b0);
    check_bit("arst_present", bus.present_o, 1'b0);
    pres_m = 1'b0;
    dbc_m  = 0;
    tick();
    tick();
    cyc   = 0;
    rst_n = 1'b1;
    scan_period("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
